// File: rtl/mux_n_pipe.sv
// N:1 operand selector feeding a registered 2-entry FIFO with valid/ready on both sides.
// Out-of-range selects push DEFAULT, tag the entry and raise a sticky error.
module mux_n_pipe #(
  parameter int unsigned      WIDTH   = 32,
  parameter int unsigned      N       = 4,
  parameter int unsigned      SEL_W   = 2,
  parameter logic [WIDTH-1:0] DEFAULT = '0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [SEL_W-1:0]   sel_i,
  input  logic [N*WIDTH-1:0] data_in_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [WIDTH-1:0]   data_out_o,
  output logic               sel_err_o,
  output logic               err_sticky_o,
  input  logic               err_clr_i
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e             state_q, state_d;
  logic             push, pop;
  logic [WIDTH-1:0] lane [N];
  logic [WIDTH-1:0] sel_data;
  logic             sel_oor;
  logic [WIDTH-1:0] mem_q [2];
  logic             err_q [2];
  logic             rd_ptr_q, wr_ptr_q;
  logic             err_sticky_q;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign lane[gi] = data_in_i[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign sel_oor = (int'(sel_i) >= int'(N));

  always_comb begin
    sel_data = DEFAULT;
    for (int i = 0; i < int'(N); i++) begin
      if (int'(sel_i) == i) sel_data = lane[i];
    end
  end

  assign push = in_valid_i & in_ready_o;
  assign pop  = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= EMPTY;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY:   if (push) state_d = ONE;
      ONE:     if (push && !pop) state_d = FULL;
               else if (pop && !push) state_d = EMPTY;
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q != FULL);
    out_valid_o = (state_q != EMPTY);
  end

  // Head is read straight from storage, so a push into an empty FIFO is visible right after its edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
        err_q[i] <= 1'b0;
      end
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= sel_data;
        err_q[wr_ptr_q] <= sel_oor;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      if (push && sel_oor) err_sticky_q <= 1'b1;
      else if (err_clr_i)  err_sticky_q <= 1'b0;
    end
  end

  assign data_out_o   = mem_q[rd_ptr_q];
  assign sel_err_o    = err_q[rd_ptr_q];
  assign err_sticky_o = err_sticky_q;

endmodule
